// File: rtl/key_pkg.sv
// Shared definitions for the panel-key debouncer.
// Contents:
//   key_state_e - per-channel debounce FSM state
//   KEY_E/U/D/L/R - bit index of each panel key in the key vectors
//   max3() - helper used to size the shared down-counter
package key_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } key_state_e;

    localparam int unsigned KEY_E = 0;
    localparam int unsigned KEY_U = 1;
    localparam int unsigned KEY_D = 2;
    localparam int unsigned KEY_L = 3;
    localparam int unsigned KEY_R = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: two-flop synchronizer, four-state FSM and a
// saturating down-counter. Emits a one-cycle press pulse on confirmed release.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while held; release after
// any repeat pulse is then silent).
// Ports:
//   clkin          clock
//   rst            asynchronous active-high reset
//   i_key_n        raw key pad, low = pressed
//   o_level        debounced state, 1 = held
//   o_press        registered one-cycle action pulse
//   o_press_next   next-cycle value of o_press (lets the top register an OR
//                  that lines up with o_press)
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic clkin,
    input  logic rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_press_next
);

    localparam int unsigned CNT_W = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    // The load value is one less than the window because the cycle that sees
    // the counter at zero is itself the last stable cycle of the window.
    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEB_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
`endif

    logic [1:0]       r_sync;
    logic             w_key_s;
    key_state_e       r_state;
    key_state_e       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_level;
    logic             w_level_d;
    logic             r_press;
    logic             w_press_d;
`ifdef KEY_REPEAT_EN
    logic             r_rep_fired;
    logic             w_rep_fired_d;
`endif

    assign w_key_s = r_sync[1];

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= StIdle;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_level <= w_level_d;
            r_press <= w_press_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_rep_fired <= 1'b0;
        end else begin
            r_rep_fired <= w_rep_fired_d;
        end
    end
`endif

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_level_d = r_level;
        w_press_d = 1'b0;
`ifdef KEY_REPEAT_EN
        w_rep_fired_d = r_rep_fired;
`endif
        case (r_state)
            StIdle: begin
                if (!w_key_s) begin
                    w_state_d = StPressWait;
                    w_cnt_d   = DEB_LOAD;
                end
            end
            StPressWait: begin
                if (w_key_s) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (r_cnt == '0) begin
                    w_state_d = StHeld;
                    w_level_d = 1'b1;
`ifdef KEY_REPEAT_EN
                    w_cnt_d   = DELAY_LOAD;
`endif
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StHeld: begin
                if (w_key_s) begin
                    w_state_d = StReleaseWait;
                    w_cnt_d   = DEB_LOAD;
                end
`ifdef KEY_REPEAT_EN
                else if (r_cnt == '0) begin
                    w_press_d     = 1'b1;
                    w_rep_fired_d = 1'b1;
                    w_cnt_d       = PERIOD_LOAD;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
`endif
            end
            StReleaseWait: begin
                if (!w_key_s) begin
                    // Release bounce: back to held, level untouched.
                    w_state_d = StHeld;
`ifdef KEY_REPEAT_EN
                    w_cnt_d   = r_rep_fired ? PERIOD_LOAD : DELAY_LOAD;
`else
                    w_cnt_d   = '0;
`endif
                end else if (r_cnt == '0) begin
                    w_state_d = StIdle;
                    w_level_d = 1'b0;
`ifdef KEY_REPEAT_EN
                    w_press_d     = !r_rep_fired;
                    w_rep_fired_d = 1'b0;
`else
                    w_press_d = 1'b1;
`endif
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign o_level      = r_level;
    assign o_press      = r_press;
    assign o_press_next = w_press_d;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounces and edge-detects the active-low panel keys feeding the countdown
// timer FSM. Each key gets an independent key_debounce_ch; any_press is the
// registered OR of all press pulses, aligned with press.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while a key is held).
// Ports:
//   clkin      sole clock
//   rst        asynchronous active-high reset
//   keys_n     raw key pads, low = pressed ([0]=enter,[1]=up,[2]=down,
//              [3]=left,[4]=right)
//   level      debounced key state, 1 = held
//   press      one-cycle pulse per accepted key action
//   any_press  OR of press, same cycle
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int unsigned NKEYS         = 5,
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic [NKEYS-1:0] keys_n,
    output logic [NKEYS-1:0] level,
    output logic [NKEYS-1:0] press,
    output logic             any_press
);

    logic [NKEYS-1:0] w_press_next;
    logic             r_any_press;

    for (genvar g = 0; g < NKEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clkin        (clkin),
            .rst          (rst),
            .i_key_n      (keys_n[g]),
            .o_level      (level[g]),
            .o_press      (press[g]),
            .o_press_next (w_press_next[g])
        );
    end

    // Built from the channels' next-press values so it rises with press.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_next;
        end
    end

    assign any_press = r_any_press;

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Debounces and edge-detects the five active-low panel keys (enter, up, down, left, right) that feed the countdown timer's setup/run FSM. It converts raw bouncing pad inputs into clean one-cycle `press` pulses on confirmed release, so the timer stage no longer carries per-key debounce counters. It sits directly upstream of the timer FSM in the `clkin` domain.

## Interface
- `NKEYS`, 5: number of key channels.
- `DEB_CYCLES`, 1000000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz).
- `REPEAT_DELAY`, 25000000: hold time before the first auto-repeat pulse. Used only with `KEY_REPEAT_EN`.
- `REPEAT_PERIOD`, 10000000: interval between later auto-repeat pulses. Used only with `KEY_REPEAT_EN`.
- `clkin`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `keys_n`  in  NKEYS  raw key pads, low = pressed; bit order is [0]=enter, [1]=up, [2]=down, [3]=left, [4]=right.
- `level`  out  NKEYS  debounced key state, 1 = held.
- `press`  out  NKEYS  one-cycle pulse per accepted key action.
- `any_press`  out  1  OR of `press`, registered in the same cycle.

## Operation
- Each channel has a two-flop synchronizer, then a four-state FSM with a down-counter.
- Synchronizer reset value is 1 (released).
- States:
  - IDLE: synchronized input is high. When it goes low, load the counter and go to PRESS_WAIT.
  - PRESS_WAIT: if the input goes high, return to IDLE (bounce rejected). After DEB_CYCLES consecutive low cycles, go to HELD and set `level`=1.
  - HELD: when the input goes high, go to RELEASE_WAIT.
  - RELEASE_WAIT: if the input goes low, return to HELD; `level` stays 1 and no pulse is emitted. After DEB_CYCLES consecutive high cycles, go to IDLE, clear `level`, and pulse `press` for one cycle.
- A pulse is emitted on release, never on press, so a held key generates exactly one action.
- Channels are fully independent. Several `press` bits may assert in the same cycle, and the downstream stage resolves any priority.
- Counter width is $clog2(max(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). The counter saturates and never wraps.
- Reset asserted mid-operation forces every channel to IDLE immediately and clears all outputs. Keys still held after reset deassertion must pass a full PRESS_WAIT before they count.

## Timing
- Reset values: `level`=0, `press`=0, `any_press`=0, FSMs in IDLE, counters 0.
- Latency: a clean raw edge sampled at edge 0 updates `level` and `press` after edge DEB_CYCLES+2.
  - 2 cycles are the synchronizer.
  - DEB_CYCLES cycles are the stable count; the last count cycle registers the output.
- `press` is high for exactly one `clkin` cycle and has no handshake. The consumer must sample it every cycle.
- A glitch shorter than DEB_CYCLES synchronized cycles never changes `level` or `press`.

## Configuration
- `KEY_REPEAT_EN` defined:
  - In HELD, the counter times the hold. After REPEAT_DELAY cycles, `press` pulses once, then again every REPEAT_PERIOD cycles while the key stays held.
  - If at least one repeat pulse fired, the later confirmed release emits no pulse.
  - Intended for the up and down keys during digit setup.
- `KEY_REPEAT_EN` undefined: HELD only waits for release, and the REPEAT_* parameters are ignored.

## Structure
- Package `key_pkg` holds:
  - the channel state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - key index constants KEY_E=0, KEY_U=1, KEY_D=2, KEY_L=3, KEY_R=4.
- Sub-module `key_debounce_ch` is one channel: synchronizer, FSM, counter. The top instantiates it NKEYS times in a generate loop and registers `any_press`.

## Test plan
Bench uses DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Clean press then release of key 1: `keys_n[1]` low for 10 cycles, then high. Expect `level[1]`=1 six cycles after the fall, then a single `press[1]` pulse and `level[1]`=0 six cycles after the rise; `any_press` pulses with it.
- Bounce rejection: `keys_n[0]` toggles every 2 cycles for 20 cycles, then stays high. Expect `level` and `press` to stay 0 throughout.
- Release bounce: hold key 2, then give a 3-cycle high glitch. Expect `level[2]` to stay 1 and no pulse; the final clean release gives exactly one `press[2]`.
- Simultaneous release: keys 3 and 4 released on the same edge. Expect `press`=5'b11000 for one cycle.
- Reset mid-operation: assert `rst` while `level[1]`=1. Expect all outputs 0 asynchronously. After deassertion with the key still held, expect `level[1]`=1 only after a new 4-cycle stable window and no spurious `press`.
- With `KEY_REPEAT_EN` defined, hold key 1 for 50 cycles after `level` rises. Expect pulses at hold cycles 20, 28, 36 and 44, and no pulse on release.
